// File: rtl/led_rate_scheduler.sv
// Blink-rate scheduler for the LED strip path.
// A down-counter prescaler, reloaded from the rate selected by MOD, toggles the
// `ok` strobe once per period. A rate change takes effect only when the current
// period expires, so `ok` never sees a shortened or stretched period mid-flight.
module led_rate_scheduler #(
  parameter int CNT_W    = 24,
  parameter int DIV_SLOW = 100,
  parameter int DIV_MED  = 50,
  parameter int DIV_FAST = 10
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [1:0]  MOD,
  output logic        ok,
  output logic        tick,
  output logic [1:0]  active_mod,
  output logic [15:0] toggles
);

  // Counter reload values: a period of DIV cycles counts DIV-1 down to 0.
  localparam logic [CNT_W-1:0] RLD_SLOW = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] RLD_MED  = CNT_W'(DIV_MED - 1);
  localparam logic [CNT_W-1:0] RLD_FAST = CNT_W'(DIV_FAST - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ok_q;
  logic              tick_q;
  logic [1:0]        active_mod_q;
  logic [15:0]       toggles_q;

  // Map a rate select onto the counter reload value (0 is never loaded while running).
  function automatic logic [CNT_W-1:0] reload_of(input logic [1:0] m);
    case (m)
      2'd1:    reload_of = RLD_SLOW;
      2'd2:    reload_of = RLD_MED;
      2'd3:    reload_of = RLD_FAST;
      default: reload_of = '0;
    endcase
  endfunction

  // Scheduler FSM: all outputs are registered here, so MOD never reaches them combinationally.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ok_q         <= 1'b0;
      tick_q       <= 1'b0;
      active_mod_q <= 2'd0;
      toggles_q    <= 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          ok_q   <= 1'b0;
          tick_q <= 1'b0;
          if (MOD != 2'd0) begin
            state_q      <= RUN;
            active_mod_q <= MOD;
            cnt_q        <= reload_of(MOD);
            toggles_q    <= 16'd0;
          end
        end
        RUN: begin
          if (MOD == 2'd0) begin
            // Disabling wins over a coinciding expiry: no toggle, no count.
            state_q      <= IDLE;
            ok_q         <= 1'b0;
            tick_q       <= 1'b0;
            active_mod_q <= 2'd0;
          end else if (cnt_q != '0) begin
            // Mid-period: keep counting at the old rate even if MOD changed.
            cnt_q  <= cnt_q - 1'b1;
            tick_q <= 1'b0;
          end else begin
            // Period boundary: toggle, and adopt whatever MOD is right now.
            ok_q         <= ~ok_q;
            tick_q       <= 1'b1;
            toggles_q    <= toggles_q + 16'd1;
            cnt_q        <= reload_of(MOD);
            active_mod_q <= MOD;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ok         = ok_q;
  assign tick       = tick_q;
  assign active_mod = active_mod_q;
  assign toggles    = toggles_q;

endmodule
